// File: rtl/dice_pkg.sv
// dice_pkg: shared FSM states, face limits and pip patterns for the dice display blocks
package dice_pkg;
    typedef enum logic [1:0] {IDLE, ROLLING, SETTLE} dice_state_t;
    localparam logic [2:0] FACE_MIN = 3'd1;
    localparam logic [2:0] FACE_MAX = 3'd6;
    localparam logic [6:0] PIPS_1 = 7'b0000001;
    localparam logic [6:0] PIPS_2 = 7'b1000010;
    localparam logic [6:0] PIPS_3 = 7'b1000011;
    localparam logic [6:0] PIPS_4 = 7'b1100110;
    localparam logic [6:0] PIPS_5 = 7'b1100111;
    localparam logic [6:0] PIPS_6 = 7'b1111110;
endpackage

// File: rtl/dice_pips.sv
// dice_pips: decodes a 3-bit face into the 7-LED pip pattern
// Ports: face (3) in, pips (7) out; bit0 centre, bit1/2 top L/R, bit3/4 mid L/R, bit5/6 bottom L/R; faces 0 and 7 are dark
module dice_pips
    import dice_pkg::*;
(
    input  logic [2:0] face,
    output logic [6:0] pips
);
    always_comb
        pips = face == 3'd1 ? PIPS_1 :
               face == 3'd2 ? PIPS_2 :
               face == 3'd3 ? PIPS_3 :
               face == 3'd4 ? PIPS_4 :
               face == 3'd5 ? PIPS_5 :
               face == 3'd6 ? PIPS_6 : 7'b0000000;
endmodule

// File: rtl/dice_result_capture.sv
// dice_result_capture: captures the final dice face on button release, validates it and keeps saturating statistics
// Ports: clk, rst (async, active-high), button, throw[2:0], clear (sync stats/error clear);
//        result[2:0], result_valid (1-cycle pulse), pips[6:0], error (sticky), roll_count[CNT_W], roll_sum[SUM_W]
// Optional: define DICE_HIST_EN to add hist[6*CNT_W], one saturating bin per face (bin f-1 counts face f)
module dice_result_capture
    import dice_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int SUM_W    = 12,
    parameter int MIN_ROLL = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             button,
    input  logic [2:0]       throw,
    input  logic             clear,
    output logic [2:0]       result,
    output logic             result_valid,
    output logic [6:0]       pips,
    output logic             error,
`ifdef DICE_HIST_EN
    output logic [6*CNT_W-1:0] hist,
`endif
    output logic [CNT_W-1:0] roll_count,
    output logic [SUM_W-1:0] roll_sum
);
    localparam int LW = $clog2(MIN_ROLL + 1);
    dice_state_t state;
    logic [LW-1:0] roll_len;
    logic legal, capture, bad;
    logic [SUM_W:0] sum_ext;
    assign legal   = throw >= FACE_MIN && throw <= FACE_MAX;
    assign capture = state == SETTLE && legal;
    assign bad     = state == SETTLE && !legal;
    // one spare bit catches the carry so an overflowing add clamps to all-ones
    assign sum_ext = {1'b0, roll_sum} + {{(SUM_W-2){1'b0}}, throw};
`ifdef DICE_HIST_EN
    logic [5:0][CNT_W-1:0] bins;
    logic [2:0] bin_idx;
    assign bin_idx = throw - 3'd1;
    assign hist = bins;
`endif
    dice_pips u_pips (.face(result), .pips(pips));
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state        <= IDLE;
            roll_len     <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            error        <= 1'b0;
            roll_count   <= '0;
            roll_sum     <= '0;
`ifdef DICE_HIST_EN
            bins         <= '0;
`endif
        end else begin
            result_valid <= capture;
            if (capture)
                result <= throw;
            case (state)
                IDLE:
                    if (button) begin
                        state    <= ROLLING;
                        roll_len <= LW'(1);
                    end
                ROLLING:
                    if (button)
                        roll_len <= roll_len < LW'(MIN_ROLL) ? roll_len + LW'(1) : roll_len;
                    else
                        state <= roll_len >= LW'(MIN_ROLL) ? SETTLE : IDLE;
                default:
                    state <= IDLE;
            endcase
            // clear beats a coincident capture for statistics and error only
            if (clear) begin
                error      <= 1'b0;
                roll_count <= '0;
                roll_sum   <= '0;
`ifdef DICE_HIST_EN
                bins       <= '0;
`endif
            end else begin
                if (bad)
                    error <= 1'b1;
                if (capture) begin
                    roll_count <= &roll_count ? roll_count : roll_count + CNT_W'(1);
                    roll_sum   <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
`ifdef DICE_HIST_EN
                    bins[bin_idx] <= &bins[bin_idx] ? bins[bin_idx] : bins[bin_idx] + CNT_W'(1);
`endif
                end
            end
        end
endmodule

// File: tb/tb_dice_result_capture.sv
// tb_dice_result_capture: randomized self-checking bench against a behavioural roll/statistics model
module tb_dice_result_capture;
    localparam int CNT_W = 2, SUM_W = 6, MIN_ROLL = 4;
    logic clk = 1'b0, rst = 1'b1, button = 1'b0, clear = 1'b0;
    logic [2:0] throw = 3'd0;
    logic [2:0] result;
    logic result_valid, error;
    logic [6:0] pips;
    logic [CNT_W-1:0] roll_count;
    logic [SUM_W-1:0] roll_sum;
`ifdef DICE_HIST_EN
    logic [6*CNT_W-1:0] hist;
`endif
    dice_result_capture #(.CNT_W(CNT_W), .SUM_W(SUM_W), .MIN_ROLL(MIN_ROLL)) dut (
        .clk(clk), .rst(rst), .button(button), .throw(throw), .clear(clear),
        .result(result), .result_valid(result_valid), .pips(pips), .error(error),
`ifdef DICE_HIST_EN
        .hist(hist),
`endif
        .roll_count(roll_count), .roll_sum(roll_sum));
    always #5 clk = ~clk;
    int checks = 0, errors = 0;
    int m_result = 0, m_count = 0, m_sum = 0, m_err = 0;
    int m_hist[6] = '{default: 0};
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int SUM_MAX = (1 << SUM_W) - 1;
    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    function automatic int pip_of(input int f);
        case (f)
            1: return 7'b0000001;
            2: return 7'b1000010;
            3: return 7'b1000011;
            4: return 7'b1100110;
            5: return 7'b1100111;
            6: return 7'b1111110;
            default: return 0;
        endcase
    endfunction
    task automatic check_all(input string tag, input int exp_valid);
        check({tag, ".valid"}, result_valid, exp_valid);
        check({tag, ".result"}, result, m_result);
        check({tag, ".pips"}, pips, pip_of(m_result));
        check({tag, ".error"}, error, m_err);
        check({tag, ".count"}, roll_count, m_count);
        check({tag, ".sum"}, roll_sum, m_sum);
`ifdef DICE_HIST_EN
        for (int f = 0; f < 6; f++) check({tag, ".hist"}, hist[f*CNT_W +: CNT_W], m_hist[f]);
`endif
    endtask
    task automatic model_clear();
        m_count = 0;
        m_sum = 0;
        m_err = 0;
        m_hist = '{default: 0};
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic roll(input int len, input int face, input bit clr);
        bit acc = len >= MIN_ROLL;
        bit ok = face >= 1 && face <= 6;
        button = 1'b1;
        for (int i = 0; i < len; i++) begin
            throw = 3'($urandom_range(0, 7));
            tick();
        end
        throw = 3'(face);
        button = 1'b0;
        tick();
        check("release.valid", result_valid, 0);
        clear = clr;
        tick();
        clear = 1'b0;
        if (acc && ok) begin
            m_result = face;
            m_count = m_count + 1 > CNT_MAX ? CNT_MAX : m_count + 1;
            m_sum = m_sum + face > SUM_MAX ? SUM_MAX : m_sum + face;
            m_hist[face-1] = m_hist[face-1] + 1 > CNT_MAX ? CNT_MAX : m_hist[face-1] + 1;
        end
        if (acc && !ok) m_err = 1;
        if (clr) model_clear();
        check_all("capture", int'(acc && ok));
        tick();
        check("after.valid", result_valid, 0);
    endtask
    initial begin
        #2;
        check_all("reset", 0);
        #10 rst = 1'b0;
        tick();
        roll(10, 5, 0);
        check("basic.count", roll_count, 1);
        check("basic.pips", pips, 7'b1100111);
        roll(2, 4, 0);
        roll(MIN_ROLL - 1, 6, 0);
        roll(MIN_ROLL, 7, 0);
        check("illegal.error", error, 1);
        roll(6, 3, 0);
        check("legal_after_err.error", error, 1);
        roll(5, 0, 0);
        roll(5, 2, 1);
        check("clear_cap.result", result, 2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_clear();
        check_all("idle_clear", 0);
        for (int i = 0; i < 12; i++) roll(4 + i % 3, 6, 0);
        check("sat.count", roll_count, CNT_MAX);
        check("sat.sum", roll_sum, SUM_MAX);
        for (int i = 0; i < 60; i++)
            roll($urandom_range(1, 8), $urandom_range(0, 9) < 8 ? $urandom_range(1, 6) : 7 * $urandom_range(0, 1),
                 $urandom_range(0, 7) == 0);
        button = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        #2;
        m_result = 0;
        model_clear();
        check_all("midroll_rst", 0);
        button = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        roll(5, 1, 0);
        check("fresh.count", roll_count, 1);
        check("fresh.pips", pips, 7'b0000001);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
